sqrt_ctrl_16bit: RTL and testbench



---
 rtl/sqrt_ctrl_16bit.sv | 131 +++++++++++++
 tb/tb_sqrt_ctrl_16bit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_ctrl_16bit.sv
// Integer square root controller: odd-number subtraction driving a shared
// AddSubMax ALU; returns floor(sqrt(N)) and remainder.
module sqrt_ctrl_16bit #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] din,
  input  logic [W-1:0] alu_m,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0]   alu_op,
  output logic [7:0]   root,
  output logic [W-1:0] rem,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMP  = 3'd1,
    S_SUB  = 3'd2,
    S_INCO = 3'd3,
    S_INCQ = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_MAX  = 2'b11;

  state_t       state;
  logic [W-1:0] r_q;
  logic [W-1:0] odd_q;
  logic [W-1:0] q_q;

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = OP_PASS;
    unique case (state)
      S_CMP: begin
        alu_op = OP_MAX;
        alu_a  = r_q;
        alu_b  = odd_q;
      end
      S_SUB: begin
        alu_op = OP_SUB;
        alu_a  = r_q;
        alu_b  = odd_q;
      end
      S_INCO: begin
        alu_op = OP_ADD;
        alu_a  = odd_q;
        alu_b  = W'(2);
      end
      S_INCQ: begin
        alu_op = OP_ADD;
        alu_a  = q_q;
        alu_b  = W'(1);
      end
      default: begin
        alu_op = OP_PASS;
        alu_a  = '0;
        alu_b  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      r_q   <= '0;
      odd_q <= '0;
      q_q   <= '0;
      root  <= '0;
      rem   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_q   <= din;
            odd_q <= W'(1);
            q_q   <= '0;
            busy  <= 1'b1;
            state <= S_CMP;
          end
        end
        // max(R,odd)==R means R>=odd, so another odd fits
        S_CMP: begin
          if (alu_m == r_q) begin
            state <= S_SUB;
          end else begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_SUB: begin
          r_q   <= alu_m;
          state <= S_INCO;
        end
        S_INCO: begin
          odd_q <= alu_m;
          state <= S_INCQ;
        end
        S_INCQ: begin
          q_q   <= alu_m;
          state <= S_CMP;
        end
        S_DONE: begin
          root  <= q_q[7:0];
          rem   <= r_q;
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_ctrl_16bit.sv
// Bench for sqrt_ctrl_16bit: closed-form iteration model checked every
// cycle, plus directed literal expectations.
module tb_sqrt_ctrl_16bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] din;
  logic [15:0] alu_m;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [1:0]  alu_op;
  logic [7:0]  root;
  logic [15:0] rem;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  sqrt_ctrl_16bit dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .din    (din),
    .alu_m  (alu_m),
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alu_op (alu_op),
    .root   (root),
    .rem    (rem),
    .busy   (busy),
    .done   (done)
  );

  // shared ALU
  always_comb begin
    case (alu_op)
      2'b00:   alu_m = alu_a;
      2'b01:   alu_m = alu_a + alu_b;
      2'b10:   alu_m = alu_a - alu_b;
      default: alu_m = (alu_a > alu_b) ? alu_a : alu_b;
    endcase
  end

  int checks   = 0;
  int failures = 0;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endfunction

  function automatic int isqrt(int n);
    int k = 0;
    while ((k + 1) * (k + 1) <= n) k++;
    return k;
  endfunction

  // model: a launch takes 4k+1 edges to reach DONE
  bit   m_idle;
  bit   e_done;
  bit   e_busy;
  int   m_left;
  int   m_n;
  int   m_k;
  int   e_root;
  int   e_rem;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idle <= 1'b1;
      e_done <= 1'b0;
      e_busy <= 1'b0;
      m_left <= 0;
      m_n    <= 0;
      m_k    <= 0;
      e_root <= 0;
      e_rem  <= 0;
    end else if (e_done) begin
      e_root <= m_k;
      e_rem  <= m_n - m_k * m_k;
      e_done <= 1'b0;
      e_busy <= 1'b0;
      m_idle <= 1'b1;
    end else if (m_idle) begin
      if (start) begin
        m_n    <= int'(din);
        m_k    <= isqrt(int'(din));
        m_left <= 4 * isqrt(int'(din)) + 1;
        m_idle <= 1'b0;
        e_busy <= 1'b1;
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 1) e_done <= 1'b1;
    end
  end

  always @(negedge clk) begin
    int i, j, ea, eb, eo;
    if (!rst) begin
      ea = 0;
      eb = 0;
      eo = 0;
      if (e_busy && !e_done) begin
        i = 4 * m_k + 1 - m_left;
        j = i / 4;
        case (i % 4)
          0: begin eo = 3; ea = m_n - j * j; eb = 2 * j + 1; end
          1: begin eo = 2; ea = m_n - j * j; eb = 2 * j + 1; end
          2: begin eo = 1; ea = 2 * j + 1;   eb = 2;         end
          default: begin eo = 1; ea = j;     eb = 1;         end
        endcase
      end
      chk("done", int'(done), int'(e_done));
      chk("busy", int'(busy), int'(e_busy));
      chk("root", int'(root), e_root);
      chk("rem", int'(rem), e_rem);
      chk("alu_op", int'(alu_op), eo);
      chk("alu_a", int'(alu_a), ea);
      chk("alu_b", int'(alu_b), eb);
    end
  end

  // launch n; optionally pulse start with pdin at cycle pat
  task automatic go(input logic [15:0] n, input int pat,
                    input logic [15:0] pdin,
                    output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1;
    din   = n;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    bcnt  = int'(busy);
    while (!done && lat < 2000) begin
      @(negedge clk);
      lat++;
      if (lat == pat) begin
        start = 1'b1;
        din   = pdin;
      end else begin
        start = 1'b0;
      end
      bcnt += int'(busy);
    end
    start = 1'b0;
    if (lat >= 2000) chk("timeout", 1, 0);
    @(negedge clk);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("timeout", 1, 0);
  endtask

  int lat;
  int bcnt;
  logic [15:0] sweep [17] = '{
    16'd1, 16'd2, 16'd3, 16'd4, 16'd8, 16'd9, 16'd15, 16'd24,
    16'd25, 16'd255, 16'd256, 16'd1000, 16'd4095, 16'd4096,
    16'd65024, 16'd65025, 16'd65280
  };

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    din   = '0;
    #1;
    chk("rst_root", int'(root), 0);
    chk("rst_rem", int'(rem), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    go(16'd0, -1, 16'd0, lat, bcnt);
    chk("n0_lat", lat, 1);
    chk("n0_busy_cycles", bcnt, 2);
    chk("n0_root", int'(root), 0);
    chk("n0_rem", int'(rem), 0);

    go(16'd16, -1, 16'd0, lat, bcnt);
    chk("n16_lat", lat, 17);
    chk("n16_root", int'(root), 4);
    chk("n16_rem", int'(rem), 0);

    go(16'd65535, -1, 16'd0, lat, bcnt);
    chk("nmax_lat", lat, 1021);
    chk("nmax_done_pulse", int'(done), 0);
    chk("nmax_root", int'(root), 255);
    chk("nmax_rem", int'(rem), 510);

    @(negedge clk);
    start = 1'b1;
    din   = 16'd1000;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_root", int'(root), 0);
    chk("abort_rem", int'(rem), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    go(16'd1000, -1, 16'd0, lat, bcnt);
    chk("n1000_lat", lat, 125);
    chk("n1000_root", int'(root), 31);
    chk("n1000_rem", int'(rem), 39);

    go(16'd100, 10, 16'd9, lat, bcnt);
    chk("n100_lat", lat, 41);
    chk("n100_root", int'(root), 10);
    chk("n100_rem", int'(rem), 0);
    chk("n100_idle", int'(busy), 0);

    @(negedge clk);
    start = 1'b1;
    din   = 16'd2;
    wait_done();
    din = 16'd3;
    @(negedge clk);
    chk("b2b_root2", int'(root), 1);
    chk("b2b_rem2", int'(rem), 1);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_relaunch", int'(busy), 1);
    wait_done();
    @(negedge clk);
    chk("b2b_root3", int'(root), 1);
    chk("b2b_rem3", int'(rem), 2);

    foreach (sweep[s]) begin
      go(sweep[s], -1, 16'd0, lat, bcnt);
      chk("sweep_lat", lat, 4 * isqrt(int'(sweep[s])) + 1);
      chk("sweep_root", int'(root), isqrt(int'(sweep[s])));
      chk("sweep_rem", int'(rem),
          int'(sweep[s]) - isqrt(int'(sweep[s])) ** 2);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
